// File: rtl/example_text_memory_loader_if.sv
// Byte-stream input and text-memory write bus of the program image loader.
// The loader takes the slave side; a host or testbench takes the master side.
interface example_text_memory_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_write_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, mem_write_enable, mem_address, mem_write_data
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, mem_write_enable, mem_address, mem_write_data
  );
endinterface

// File: rtl/example_text_memory_loader.sv
// Loads a program image into text memory: assembles little-endian words from a
// byte stream and writes them to consecutive addresses from TEXT_BEGIN.
module example_text_memory_loader #(
  parameter logic [31:0] TEXT_BEGIN = 32'h00400000,
  parameter int          TEXT_BITS  = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [TEXT_BITS-2:0]      length_words,
  example_text_memory_loader_if.slave bus,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [TEXT_BITS-2:0]      words_written,
  output logic [31:0]               checksum
);

  localparam int TW = TEXT_BITS - 1;
  // Capacity 2^(TEXT_BITS-2) words is the MSB of a TEXT_BITS-1 bit count.
  localparam logic [TW-1:0] CAPACITY = {1'b1, {(TW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERROR} state_t;

  state_t        state_q, state_d;
  logic [1:0]    byte_idx;
  logic [23:0]   word_buf;
  logic [TW-1:0] length_q;
  logic [31:0]   addr_q;

  logic          start_ok;
  logic          xfer;
  logic          last_byte;
  logic [31:0]   word;
  logic [TW-1:0] written_inc;

  assign start_ok    = start && (state_q != LOAD);
  assign xfer        = bus.byte_valid && (state_q == LOAD);
  assign last_byte   = xfer && (byte_idx == 2'd3);
  assign word        = {bus.byte_data, word_buf};
  assign written_inc = words_written + TW'(1);

  assign bus.byte_ready = (state_q == LOAD);
  assign busy           = (state_q == LOAD);
  assign done           = (state_q == DONE);
  assign error          = (state_q == ERROR);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD: begin
        if (last_byte && (written_inc == length_q)) state_d = DONE;
      end
      default: begin
        if (start) begin
          if (length_words == '0)            state_d = DONE;
          else if (length_words > CAPACITY)  state_d = ERROR;
          else                               state_d = LOAD;
        end
      end
    endcase
  end

  // Assembly and write issue: the strobe is a single-cycle pulse, address and
  // data hold their last values between writes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      byte_idx             <= '0;
      word_buf             <= '0;
      length_q             <= '0;
      addr_q               <= TEXT_BEGIN;
      words_written        <= '0;
      checksum             <= '0;
      bus.mem_write_enable <= 1'b0;
      bus.mem_address      <= '0;
      bus.mem_write_data   <= '0;
    end else begin
      bus.mem_write_enable <= 1'b0;
      if (start_ok) begin
        byte_idx      <= '0;
        addr_q        <= TEXT_BEGIN;
        words_written <= '0;
        checksum      <= '0;
        if (length_words <= CAPACITY) length_q <= length_words;
      end else if (xfer) begin
        byte_idx <= byte_idx + 2'd1;
        unique case (byte_idx)
          2'd0: word_buf[7:0]   <= bus.byte_data;
          2'd1: word_buf[15:8]  <= bus.byte_data;
          2'd2: word_buf[23:16] <= bus.byte_data;
          default: begin
            bus.mem_write_enable <= 1'b1;
            bus.mem_address      <= addr_q;
            bus.mem_write_data   <= word;
            addr_q               <= addr_q + 32'd4;
            words_written        <= written_inc;
            checksum             <= checksum + word;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_example_text_memory_loader.sv
// Randomized self-checking bench for example_text_memory_loader against a
// word-level image model (little-endian packing, consecutive addresses, sum).
module tb_example_text_memory_loader;

  localparam logic [31:0] TB_BEGIN = 32'h00400000;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Main instance, default geometry
  example_text_memory_loader_if bus();
  logic        start;
  logic [14:0] length_words;
  logic        busy, done, error;
  logic [14:0] words_written;
  logic [31:0] checksum;

  example_text_memory_loader dut (
    .clock(clock), .reset(reset), .start(start), .length_words(length_words),
    .bus(bus), .busy(busy), .done(done), .error(error),
    .words_written(words_written), .checksum(checksum)
  );

  // Small instance: 16-byte text memory, capacity 4 words
  example_text_memory_loader_if sbus();
  logic        s_start;
  logic [2:0]  s_len;
  logic        s_busy, s_done, s_error;
  logic [2:0]  s_ww;
  logic [31:0] s_cs;

  example_text_memory_loader #(.TEXT_BITS(4)) dut_small (
    .clock(clock), .reset(reset), .start(s_start), .length_words(s_len),
    .bus(sbus), .busy(s_busy), .done(s_done), .error(s_error),
    .words_written(s_ww), .checksum(s_cs)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  logic [31:0] s_addr[$];
  logic [31:0] s_data[$];
  int          acc4[$];
  int          ready_cnt = 0;

  always @(negedge clock) begin
    if (bus.mem_write_enable) begin
      wr_addr.push_back(bus.mem_address);
      wr_data.push_back(bus.mem_write_data);
      wr_cyc.push_back(cyc);
    end
    if (sbus.mem_write_enable) begin
      s_addr.push_back(sbus.mem_address);
      s_data.push_back(sbus.mem_write_data);
    end
    if (bus.byte_ready) ready_cnt <= ready_cnt + 1;
  end

  function automatic logic [31:0] model_word(input logic [7:0] b[$], input int w);
    return {b[4*w+3], b[4*w+2], b[4*w+1], b[4*w]};
  endfunction

  function automatic logic [31:0] model_sum(input logic [7:0] b[$]);
    logic [31:0] s = '0;
    for (int w = 0; w < b.size() / 4; w++) s = s + model_word(b, w);
    return s;
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic pulse_start(input logic [14:0] len);
    start = 1'b1;
    length_words = len;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Sends bytes; records the cycle at which every 4th byte was accepted.
  task automatic send_stream(input logic [7:0] b[$], input int gap, input bit rnd);
    for (int i = 0; i < b.size(); i++) begin
      int t = 0;
      int g;
      bus.byte_valid = 1'b1;
      bus.byte_data  = b[i];
      while (!bus.byte_ready && t < 40) begin
        @(negedge clock);
        t++;
      end
      if (t >= 40) begin
        n_vec++; n_err++;
        $display("FAIL stream_timeout byte=%0d ready=%0b required=1", i, bus.byte_ready);
        bus.byte_valid = 1'b0;
        return;
      end
      @(negedge clock);
      if (i % 4 == 3) acc4.push_back(cyc);
      g = rnd ? int'($urandom_range(0, gap)) : gap;
      if (g > 0) begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'($urandom);
        repeat (g) @(negedge clock);
      end
    end
    bus.byte_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    n_vec++;
    if ({busy, done, error, bus.byte_ready, bus.mem_write_enable} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_status got=%b required=00000",
               {busy, done, error, bus.byte_ready, bus.mem_write_enable});
    end
    n_vec++;
    if ({bus.mem_address, bus.mem_write_data} !== 64'h0) begin
      n_err++;
      $display("FAIL reset_bus addr=%h data=%h required=0", bus.mem_address, bus.mem_write_data);
    end
    n_vec++;
    if ({words_written, checksum} !== 47'h0) begin
      n_err++;
      $display("FAIL reset_counters ww=%0d cs=%h required=0", words_written, checksum);
    end
    n_vec++;
    if ({s_busy, s_done, s_error, sbus.byte_ready, s_ww, s_cs} !== 39'h0) begin
      n_err++;
      $display("FAIL reset_small got=%h required=0", {s_busy, s_done, s_error, sbus.byte_ready, s_ww, s_cs});
    end
    reset = 1'b0;
    repeat (2) @(negedge clock);
    n_vec++;
    if ({busy, done, error} !== 3'b0) begin
      n_err++;
      $display("FAIL reset_stays_idle got=%b required=000", {busy, done, error});
    end
  endtask

  task automatic test_two_word();
    logic [7:0] b[$] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    logic [31:0] exp_w[2] = '{32'h12345678, 32'hDEADBEEF};
    int base = wr_addr.size();
    pulse_start(15'd2);
    n_vec++;
    if ({busy, bus.byte_ready} !== 2'b11) begin
      n_err++;
      $display("FAIL two_word_load busy/ready=%b required=11", {busy, bus.byte_ready});
    end
    send_stream(b, 0, 1'b0);
    repeat (2) @(negedge clock);
    n_vec++;
    if (wr_addr.size() - base != 2) begin
      n_err++;
      $display("FAIL two_word_count got=%0d required=2", wr_addr.size() - base);
    end
    for (int w = 0; w < 2; w++) begin
      n_vec++;
      if (wr_data[base+w] !== exp_w[w] || wr_addr[base+w] !== TB_BEGIN + 32'(4*w)) begin
        n_err++;
        $display("FAIL two_word_write%0d got=%h@%h required=%h@%h", w, wr_data[base+w],
                 wr_addr[base+w], exp_w[w], TB_BEGIN + 32'(4*w));
      end
    end
    n_vec++;
    if (wr_cyc[base+1] - wr_cyc[base] != 4) begin
      n_err++;
      $display("FAIL two_word_spacing got=%0d required=4", wr_cyc[base+1] - wr_cyc[base]);
    end
    n_vec++;
    if ({done, busy, bus.byte_ready, words_written} !== {3'b100, 15'd2}) begin
      n_err++;
      $display("FAIL two_word_done d/b/r=%b ww=%0d required=100 ww=2",
               {done, busy, bus.byte_ready}, words_written);
    end
    n_vec++;
    if (checksum !== exp_w[0] + exp_w[1]) begin
      n_err++;
      $display("FAIL two_word_checksum got=%h required=%h", checksum, exp_w[0] + exp_w[1]);
    end
    n_vec++;
    if ({bus.mem_write_enable, bus.mem_address, bus.mem_write_data} !== {1'b0, TB_BEGIN + 32'd4, exp_w[1]}) begin
      n_err++;
      $display("FAIL two_word_hold we=%0b addr=%h data=%h required=0 %h %h", bus.mem_write_enable,
               bus.mem_address, bus.mem_write_data, TB_BEGIN + 32'd4, exp_w[1]);
    end
  endtask

  task automatic test_zero_length();
    int base, rc0;
    do_reset();
    base = wr_addr.size();
    rc0 = ready_cnt;
    pulse_start(15'd0);
    n_vec++;
    if ({done, busy, error} !== 3'b100) begin
      n_err++;
      $display("FAIL zero_len_done got=%b required=100", {done, busy, error});
    end
    repeat (4) @(negedge clock);
    n_vec++;
    if (wr_addr.size() != base || ready_cnt != rc0 || done !== 1'b1) begin
      n_err++;
      $display("FAIL zero_len_quiet writes=%0d ready_cycles=%0d done=%0b required=0 0 1",
               wr_addr.size() - base, ready_cnt - rc0, done);
    end
  endtask

  task automatic test_oversize();
    logic [7:0] b[$];
    int base = s_addr.size();
    s_start = 1'b1; s_len = 3'd5;
    @(negedge clock);
    s_start = 1'b0;
    repeat (3) @(negedge clock);
    n_vec++;
    if ({s_error, s_busy, s_done, sbus.byte_ready} !== 4'b1000 || s_addr.size() != base) begin
      n_err++;
      $display("FAIL oversize_error e/b/d/r=%b writes=%0d required=1000 0",
               {s_error, s_busy, s_done, sbus.byte_ready}, s_addr.size() - base);
    end
    for (int i = 0; i < 16; i++) b.push_back(8'($urandom));
    s_start = 1'b1; s_len = 3'd4;
    @(negedge clock);
    s_start = 1'b0;
    n_vec++;
    if ({s_error, s_busy} !== 2'b01) begin
      n_err++;
      $display("FAIL oversize_restart e/b=%b required=01", {s_error, s_busy});
    end
    for (int i = 0; i < 16; i++) begin
      sbus.byte_valid = 1'b1;
      sbus.byte_data  = b[i];
      @(negedge clock);
    end
    sbus.byte_valid = 1'b0;
    repeat (2) @(negedge clock);
    n_vec++;
    if (s_addr.size() - base != 4) begin
      n_err++;
      $display("FAIL oversize_count got=%0d required=4", s_addr.size() - base);
    end
    for (int w = 0; w < 4; w++) begin
      n_vec++;
      if (s_data[base+w] !== model_word(b, w) || s_addr[base+w] !== TB_BEGIN + 32'(4*w)) begin
        n_err++;
        $display("FAIL oversize_write%0d got=%h@%h required=%h@%h", w, s_data[base+w],
                 s_addr[base+w], model_word(b, w), TB_BEGIN + 32'(4*w));
      end
    end
    n_vec++;
    if ({s_done, s_busy, s_ww} !== {2'b10, 3'd4} || s_cs !== model_sum(b)) begin
      n_err++;
      $display("FAIL oversize_done d/b=%b ww=%0d cs=%h required=10 4 %h",
               {s_done, s_busy}, s_ww, s_cs, model_sum(b));
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] b[$] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    int base = wr_addr.size();
    int abase = acc4.size();
    pulse_start(15'd2);
    send_stream(b, 3, 1'b0);
    repeat (2) @(negedge clock);
    n_vec++;
    if (wr_addr.size() - base != 2) begin
      n_err++;
      $display("FAIL bp_count got=%0d required=2", wr_addr.size() - base);
    end
    for (int w = 0; w < 2; w++) begin
      n_vec++;
      if (wr_data[base+w] !== model_word(b, w) || wr_addr[base+w] !== TB_BEGIN + 32'(4*w) ||
          wr_cyc[base+w] != acc4[abase+w]) begin
        n_err++;
        $display("FAIL bp_write%0d got=%h@%h cyc=%0d required=%h@%h cyc=%0d", w, wr_data[base+w],
                 wr_addr[base+w], wr_cyc[base+w], model_word(b, w), TB_BEGIN + 32'(4*w), acc4[abase+w]);
      end
    end
    n_vec++;
    if (checksum !== model_sum(b) || done !== 1'b1) begin
      n_err++;
      $display("FAIL bp_checksum got=%h done=%0b required=%h 1", checksum, done, model_sum(b));
    end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] part[$] = '{8'hAA, 8'hBB};
    logic [7:0] b[$]    = '{8'h01, 8'h02, 8'h03, 8'h04};
    int base;
    pulse_start(15'd2);
    send_stream(part, 0, 1'b0);
    base = wr_addr.size();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    n_vec++;
    if (wr_addr.size() != base || {busy, done, error, bus.byte_ready} !== 4'b0) begin
      n_err++;
      $display("FAIL midreset_idle writes=%0d b/d/e/r=%b required=0 0000",
               wr_addr.size() - base, {busy, done, error, bus.byte_ready});
    end
    pulse_start(15'd1);
    send_stream(b, 0, 1'b0);
    repeat (2) @(negedge clock);
    n_vec++;
    if (wr_addr.size() - base != 1 || wr_data[base] !== 32'h04030201 || wr_addr[base] !== TB_BEGIN) begin
      n_err++;
      $display("FAIL midreset_restart n=%0d got=%h@%h required=1 04030201@%h",
               wr_addr.size() - base, wr_data[base], wr_addr[base], TB_BEGIN);
    end
  endtask

  task automatic test_restart();
    logic [7:0] b[$];
    logic [7:0] h0[$];
    logic [7:0] h1[$];
    int base = wr_addr.size();
    for (int i = 0; i < 8; i++) b.push_back(8'($urandom));
    h0 = b[0:3];
    h1 = b[4:7];
    pulse_start(15'd2);
    send_stream(h0, 0, 1'b0);
    pulse_start(15'd0);
    n_vec++;
    if ({busy, done} !== 2'b10) begin
      n_err++;
      $display("FAIL restart_ignored b/d=%b required=10", {busy, done});
    end
    send_stream(h1, 0, 1'b0);
    repeat (2) @(negedge clock);
    n_vec++;
    if (wr_addr.size() - base != 2 || wr_data[base+1] !== model_word(b, 1) ||
        words_written !== 15'd2 || checksum !== model_sum(b) || done !== 1'b1) begin
      n_err++;
      $display("FAIL restart_complete n=%0d w1=%h ww=%0d cs=%h required=2 %h 2 %h",
               wr_addr.size() - base, wr_data[base+1], words_written, checksum,
               model_word(b, 1), model_sum(b));
    end
    base = wr_addr.size();
    pulse_start(15'd1);
    n_vec++;
    if ({words_written, checksum} !== 47'h0 || {busy, done} !== 2'b10) begin
      n_err++;
      $display("FAIL restart_cleared ww=%0d cs=%h b/d=%b required=0 0 10", words_written, checksum, {busy, done});
    end
    send_stream(h1, 0, 1'b0);
    repeat (2) @(negedge clock);
    n_vec++;
    if (wr_addr[base] !== TB_BEGIN || wr_data[base] !== model_word(h1, 0) ||
        words_written !== 15'd1 || checksum !== model_word(h1, 0)) begin
      n_err++;
      $display("FAIL restart_addr got=%h@%h ww=%0d cs=%h required=%h@%h 1", wr_data[base],
               wr_addr[base], words_written, checksum, model_word(h1, 0), TB_BEGIN);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      logic [7:0] b[$];
      int len = $urandom_range(1, 6);
      int base = wr_addr.size();
      int abase = acc4.size();
      for (int i = 0; i < 4 * len; i++) b.push_back(8'($urandom));
      pulse_start(15'(len));
      send_stream(b, 2, 1'b1);
      repeat (2) @(negedge clock);
      n_vec++;
      if (wr_addr.size() - base != len) begin
        n_err++;
        $display("FAIL rand%0d_count got=%0d required=%0d", it, wr_addr.size() - base, len);
      end
      for (int w = 0; w < len; w++) begin
        n_vec++;
        if (wr_data[base+w] !== model_word(b, w) || wr_addr[base+w] !== TB_BEGIN + 32'(4*w) ||
            wr_cyc[base+w] != acc4[abase+w]) begin
          n_err++;
          $display("FAIL rand%0d_write%0d got=%h@%h cyc=%0d required=%h@%h cyc=%0d", it, w,
                   wr_data[base+w], wr_addr[base+w], wr_cyc[base+w], model_word(b, w),
                   TB_BEGIN + 32'(4*w), acc4[abase+w]);
        end
      end
      n_vec++;
      if (words_written !== 15'(len) || checksum !== model_sum(b) || done !== 1'b1) begin
        n_err++;
        $display("FAIL rand%0d_status ww=%0d cs=%h done=%0b required=%0d %h 1", it,
                 words_written, checksum, done, len, model_sum(b));
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    length_words = '0;
    bus.byte_valid = 1'b0;
    bus.byte_data = '0;
    s_start = 1'b0;
    s_len = '0;
    sbus.byte_valid = 1'b0;
    sbus.byte_data = '0;
    repeat (2) @(negedge clock);
    test_reset();
    test_two_word();
    test_zero_length();
    test_oversize();
    test_backpressure();
    test_reset_mid_word();
    test_restart();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
